// File: rtl/bcd_timer_core.sv
// bcd_timer_core
//   MM:SS timer engine with BCD digits, a one-second prescaler and a
//   start/stop/delete control FSM. Counts up or down. Digits connect straight
//   to the text writer, and finish drives the alarm/colour logic.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   IDLE    | time is editable with inc_sec/inc_min, waiting for start
//   RUN     | prescaler running, time steps once per tick
//   PAUSED  | prescaler frozen, time editable, start resumes
//   DONE    | terminal value reached (or down-start at 00:00), time held
//
// Ports
//   clk          system clock, rising edge
//   reset        asynchronous, active-high, clears all state
//   start        rising edge starts/resumes (IDLE, PAUSED)
//   stop         rising edge pauses (RUN)
//   delete       rising edge clears time and returns to IDLE
//   forward      1 = count up, 0 = count down, latched on start
//   inc_sec      rising edge: seconds +1, no carry (IDLE, PAUSED)
//   inc_min      rising edge: minutes +1, wraps at max (IDLE, PAUSED)
//   sec_units    BCD seconds units
//   sec_tens     BCD seconds tens
//   min_digits   BCD minutes, least-significant digit in [3:0]
//   running      state is RUN
//   paused       state is PAUSED
//   finish       state is DONE
//   tick         one-cycle pulse on each prescaler wrap in RUN
module bcd_timer_core #(
  parameter int CLK_DIV    = 25_000_000,
  parameter int MIN_DIGITS = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic                    stop,
  input  logic                    delete,
  input  logic                    forward,
  input  logic                    inc_sec,
  input  logic                    inc_min,
  output logic [3:0]              sec_units,
  output logic [3:0]              sec_tens,
  output logic [4*MIN_DIGITS-1:0] min_digits,
  output logic                    running,
  output logic                    paused,
  output logic                    finish,
  output logic                    tick
);

  localparam int MW = 4 * MIN_DIGITS;
  localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_DIV - 1);
  localparam logic [MW-1:0] MIN_MAX    = {MIN_DIGITS{4'h9}};

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_RUN    = 2'd1;
  localparam logic [1:0] ST_PAUSED = 2'd2;
  localparam logic [1:0] ST_DONE   = 2'd3;

  // Ripple a +1 through the BCD minute digits; all-nines wraps to zero.
  function automatic logic [MW-1:0] min_inc(input logic [MW-1:0] m);
    logic [MW-1:0] r;
    logic          carry;
    r     = m;
    carry = 1'b1;
    for (int i = 0; i < MIN_DIGITS; i++) begin
      if (carry) begin
        if (m[4*i +: 4] == 4'd9) begin
          r[4*i +: 4] = 4'd0;
        end else begin
          r[4*i +: 4] = m[4*i +: 4] + 4'd1;
          carry       = 1'b0;
        end
      end
    end
    return r;
  endfunction

  function automatic logic [MW-1:0] min_dec(input logic [MW-1:0] m);
    logic [MW-1:0] r;
    logic          borrow;
    r      = m;
    borrow = 1'b1;
    for (int i = 0; i < MIN_DIGITS; i++) begin
      if (borrow) begin
        if (m[4*i +: 4] == 4'd0) begin
          r[4*i +: 4] = 4'd9;
        end else begin
          r[4*i +: 4] = m[4*i +: 4] - 4'd1;
          borrow      = 1'b0;
        end
      end
    end
    return r;
  endfunction

  logic [1:0]    state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic          dir_q, dir_d;
  logic [3:0]    su_q, su_d, st_q, st_d;
  logic [MW-1:0] min_q, min_d;
  logic          tick_q, tick_d;
  logic          running_q, paused_q, finish_q;
  logic          prev_start, prev_stop, prev_delete, prev_inc_sec, prev_inc_min;
  logic          evt_start, evt_stop, evt_delete, evt_inc_sec, evt_inc_min;

  logic [3:0]    step_su, step_st;
  logic [MW-1:0] step_min;
  logic          step_terminal;
  logic          time_zero;
  logic          editable;

  assign evt_start   = start   & ~prev_start;
  assign evt_stop    = stop    & ~prev_stop;
  assign evt_delete  = delete  & ~prev_delete;
  assign evt_inc_sec = inc_sec & ~prev_inc_sec;
  assign evt_inc_min = inc_min & ~prev_inc_min;

  assign time_zero = (min_q == '0) && (st_q == 4'd0) && (su_q == 4'd0);
  assign editable  = (state_q == ST_IDLE) || (state_q == ST_PAUSED);

  // Time value after one counting tick in the latched direction.
  always_comb begin
    step_su  = su_q;
    step_st  = st_q;
    step_min = min_q;
    if (dir_q) begin
      if (su_q == 4'd9) begin
        step_su = 4'd0;
        if (st_q == 4'd5) begin
          step_st  = 4'd0;
          step_min = min_inc(min_q);
        end else begin
          step_st = st_q + 4'd1;
        end
      end else begin
        step_su = su_q + 4'd1;
      end
    end else begin
      if (su_q == 4'd0) begin
        step_su = 4'd9;
        if (st_q == 4'd0) begin
          step_st  = 4'd5;
          step_min = min_dec(min_q);
        end else begin
          step_st = st_q - 4'd1;
        end
      end else begin
        step_su = su_q - 4'd1;
      end
    end
  end

  assign step_terminal = dir_q ?
      ((step_min == MIN_MAX) && (step_st == 4'd5) && (step_su == 4'd9)) :
      ((step_min == '0) && (step_st == 4'd0) && (step_su == 4'd0));

  // Priority chain: delete > stop > start > inc; a higher event swallows
  // every lower one in the same cycle.
  always_comb begin
    state_d = state_q;
    presc_d = presc_q;
    dir_d   = dir_q;
    su_d    = su_q;
    st_d    = st_q;
    min_d   = min_q;
    tick_d  = 1'b0;
    if (evt_delete) begin
      state_d = ST_IDLE;
      presc_d = '0;
      su_d    = 4'd0;
      st_d    = 4'd0;
      min_d   = '0;
    end else if (evt_stop) begin
      if (state_q == ST_RUN) state_d = ST_PAUSED;
    end else if (evt_start && editable) begin
      dir_d   = forward;
      presc_d = '0;
      state_d = (!forward && time_zero) ? ST_DONE : ST_RUN;
    end else if (state_q == ST_RUN) begin
      if (presc_q == PRESC_LAST) begin
        presc_d = '0;
        tick_d  = 1'b1;
        su_d    = step_su;
        st_d    = step_st;
        min_d   = step_min;
        if (step_terminal) state_d = ST_DONE;
      end else begin
        presc_d = presc_q + PW'(1);
      end
    end else if (editable) begin
      if (evt_inc_sec) begin
        if (su_q == 4'd9) begin
          su_d = 4'd0;
          st_d = (st_q == 4'd5) ? 4'd0 : st_q + 4'd1;
        end else begin
          su_d = su_q + 4'd1;
        end
      end
      if (evt_inc_min) min_d = min_inc(min_q);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      presc_q      <= '0;
      dir_q        <= 1'b0;
      su_q         <= 4'd0;
      st_q         <= 4'd0;
      min_q        <= '0;
      tick_q       <= 1'b0;
      running_q    <= 1'b0;
      paused_q     <= 1'b0;
      finish_q     <= 1'b0;
      prev_start   <= 1'b0;
      prev_stop    <= 1'b0;
      prev_delete  <= 1'b0;
      prev_inc_sec <= 1'b0;
      prev_inc_min <= 1'b0;
    end else begin
      state_q      <= state_d;
      presc_q      <= presc_d;
      dir_q        <= dir_d;
      su_q         <= su_d;
      st_q         <= st_d;
      min_q        <= min_d;
      tick_q       <= tick_d;
      // Status flags registered directly so they never glitch on state decode.
      running_q    <= (state_d == ST_RUN);
      paused_q     <= (state_d == ST_PAUSED);
      finish_q     <= (state_d == ST_DONE);
      prev_start   <= start;
      prev_stop    <= stop;
      prev_delete  <= delete;
      prev_inc_sec <= inc_sec;
      prev_inc_min <= inc_min;
    end
  end

  assign sec_units  = su_q;
  assign sec_tens   = st_q;
  assign min_digits = min_q;
  assign running    = running_q;
  assign paused     = paused_q;
  assign finish     = finish_q;
  assign tick       = tick_q;

endmodule

// File: tb/tb_bcd_timer_core.sv
module tb_bcd_timer_core;

  localparam int CLK_DIV = 4;
  localparam int S_IDLE = 0, S_RUN = 1, S_PAUSED = 2, S_DONE = 3;
  localparam int P_SEC = 0, P_MIN = 1, P_START = 2, P_STOP = 3, P_DEL = 4;

  logic clk;
  logic reset;
  logic start, stop, del, forward, inc_sec, inc_min;

  logic [3:0] su0, st0, su1, st1;
  logic [7:0] md0;
  logic [3:0] md1;
  logic run0, pau0, fin0, tick0;
  logic run1, pau1, fin1, tick1;

  int checks = 0;
  int failures = 0;

  // Reference model: time as whole minutes/seconds integers per instance.
  int m_min[2], m_sec[2], m_presc[2], m_state[2];
  bit m_dir[2], m_tick[2];
  int maxm[2] = '{99, 9};
  int ndig[2] = '{2, 1};
  bit p_start, p_stop, p_del, p_sec, p_min;

  bcd_timer_core #(.CLK_DIV(CLK_DIV), .MIN_DIGITS(2)) dut0 (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .delete(del),
    .forward(forward), .inc_sec(inc_sec), .inc_min(inc_min),
    .sec_units(su0), .sec_tens(st0), .min_digits(md0),
    .running(run0), .paused(pau0), .finish(fin0), .tick(tick0));

  bcd_timer_core #(.CLK_DIV(CLK_DIV), .MIN_DIGITS(1)) dut1 (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .delete(del),
    .forward(forward), .inc_sec(inc_sec), .inc_min(inc_min),
    .sec_units(su1), .sec_tens(st1), .min_digits(md1),
    .running(run1), .paused(pau1), .finish(fin1), .tick(tick1));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int exp_time(input int mins, input int secs, input int nd);
    int r;
    int p;
    r = 0;
    p = 1;
    for (int d = 0; d < nd; d++) begin
      r = r | (((mins / p) % 10) << (8 + 4*d));
      p = p * 10;
    end
    r = r | ((secs / 10) << 4) | (secs % 10);
    return r;
  endfunction

  function automatic int exp_stat(input int i);
    return {28'd0, m_state[i] == S_RUN, m_state[i] == S_PAUSED,
            m_state[i] == S_DONE, m_tick[i]};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_min[i] = 0; m_sec[i] = 0; m_presc[i] = 0;
      m_state[i] = S_IDLE; m_dir[i] = 0; m_tick[i] = 0;
    end
    p_start = 0; p_stop = 0; p_del = 0; p_sec = 0; p_min = 0;
  endtask

  task automatic model_step();
    bit e_start, e_stop, e_del, e_sec, e_min;
    int total, span;
    if (reset) begin
      model_reset();
      return;
    end
    e_start = start & ~p_start;
    e_stop  = stop & ~p_stop;
    e_del   = del & ~p_del;
    e_sec   = inc_sec & ~p_sec;
    e_min   = inc_min & ~p_min;
    for (int i = 0; i < 2; i++) begin
      m_tick[i] = 0;
      span = (maxm[i] + 1) * 60;
      if (e_del) begin
        m_min[i] = 0; m_sec[i] = 0; m_presc[i] = 0; m_state[i] = S_IDLE;
      end else if (e_stop) begin
        if (m_state[i] == S_RUN) m_state[i] = S_PAUSED;
      end else if (e_start && (m_state[i] == S_IDLE || m_state[i] == S_PAUSED)) begin
        m_dir[i] = forward;
        m_presc[i] = 0;
        m_state[i] = (!forward && m_min[i] == 0 && m_sec[i] == 0) ? S_DONE : S_RUN;
      end else if (m_state[i] == S_RUN) begin
        if (m_presc[i] == CLK_DIV - 1) begin
          m_presc[i] = 0;
          m_tick[i] = 1;
          total = m_min[i] * 60 + m_sec[i];
          total = m_dir[i] ? (total + 1) % span : (total + span - 1) % span;
          m_min[i] = total / 60;
          m_sec[i] = total % 60;
          if (m_dir[i] ? (total == span - 1) : (total == 0)) m_state[i] = S_DONE;
        end else begin
          m_presc[i]++;
        end
      end else if (m_state[i] == S_IDLE || m_state[i] == S_PAUSED) begin
        if (e_sec) m_sec[i] = (m_sec[i] + 1) % 60;
        if (e_min) m_min[i] = (m_min[i] + 1) % (maxm[i] + 1);
      end
    end
    p_start = start; p_stop = stop; p_del = del; p_sec = inc_sec; p_min = inc_min;
  endtask

  task automatic check_model();
    chk("model_time0", 32'({md0, st0, su0}), exp_time(m_min[0], m_sec[0], ndig[0]));
    chk("model_stat0", 32'({run0, pau0, fin0, tick0}), exp_stat(0));
    chk("model_time1", 32'({md1, st1, su1}), exp_time(m_min[1], m_sec[1], ndig[1]));
    chk("model_stat1", 32'({run1, pau1, fin1, tick1}), exp_stat(1));
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    #1;
    check_model();
    @(negedge clk);
  endtask

  task automatic set_in(input int which, input logic v);
    case (which)
      P_SEC:   inc_sec = v;
      P_MIN:   inc_min = v;
      P_START: start = v;
      P_STOP:  stop = v;
      default: del = v;
    endcase
  endtask

  task automatic pulse(input int which);
    set_in(which, 1'b1);
    step();
    set_in(which, 1'b0);
    step();
  endtask

  initial begin
    reset = 1'b1;
    start = 0; stop = 0; del = 0; forward = 0; inc_sec = 0; inc_min = 0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    chk("reset_time0", 32'({md0, st0, su0}), 32'h0);
    chk("reset_stat0", 32'({run0, pau0, fin0, tick0}), 32'h0);
    check_model();
    reset = 1'b0;

    // Down-count from 02:03 with a 4-cycle tick.
    repeat (3) pulse(P_SEC);
    repeat (2) pulse(P_MIN);
    forward = 0;
    start = 1; step(); start = 0;
    chk("t1_running", 32'(run0), 32'd1);
    chk("t1_start_time", 32'({md0, st0, su0}), 32'h0203);
    repeat (3) step();
    chk("t1_no_tick", 32'(tick0), 32'd0);
    step();
    chk("t1_tick", 32'(tick0), 32'd1);
    chk("t1_time", 32'({md0, st0, su0}), 32'h0202);
    repeat (4) step();
    chk("t1_tick_period", 32'(tick0), 32'd1);
    chk("t1_time2", 32'({md0, st0, su0}), 32'h0201);

    // Down-count 00:02 to 00:00 then DONE; start ignored afterwards.
    pulse(P_DEL);
    repeat (2) pulse(P_SEC);
    forward = 0;
    start = 1; step(); start = 0;
    repeat (7) step();
    chk("t2_pre_running", 32'(run0), 32'd1);
    step();
    chk("t2_time", 32'({md0, st0, su0}), 32'h0000);
    chk("t2_finish", 32'(fin0), 32'd1);
    chk("t2_running", 32'(run0), 32'd0);
    pulse(P_START);
    chk("t2_done_hold", 32'({fin0, md0, st0, su0}), 32'h10000);

    // Up-count to max:59 on the single-digit instance; carry on the two-digit one.
    pulse(P_DEL);
    repeat (9) pulse(P_MIN);
    repeat (58) pulse(P_SEC);
    forward = 1;
    start = 1; step(); start = 0;
    repeat (4) step();
    chk("t3_max_time1", 32'({md1, st1, su1}), 32'h959);
    chk("t3_max_finish1", 32'(fin1), 32'd1);
    chk("t3_time0", 32'({md0, st0, su0}), 32'h0959);
    repeat (4) step();
    chk("t3_carry0", 32'({md0, st0, su0}), 32'h1000);
    chk("t3_hold1", 32'({md1, st1, su1}), 32'h959);
    pulse(P_DEL);
    repeat (59) pulse(P_SEC);
    forward = 1;
    start = 1; step(); start = 0;
    repeat (4) step();
    chk("t3_carry1", 32'({md1, st1, su1}), 32'h100);
    chk("t3_carry0b", 32'({md0, st0, su0}), 32'h0100);

    // Stop with the prescaler at 2, edit, resume: next tick 4 cycles later.
    repeat (2) step();
    stop = 1; step(); stop = 0;
    chk("t4_paused", 32'({run0, pau0}), 32'h1);
    repeat (20) step();
    chk("t4_frozen", 32'({md0, st0, su0}), 32'h0100);
    pulse(P_SEC);
    chk("t4_inc_sec", 32'({md0, st0, su0}), 32'h0101);
    start = 1; step(); start = 0;
    chk("t4_resumed", 32'(run0), 32'd1);
    repeat (3) step();
    chk("t4_no_tick", 32'(tick0), 32'd0);
    step();
    chk("t4_tick", 32'(tick0), 32'd1);
    chk("t4_time", 32'({md0, st0, su0}), 32'h0102);

    // Delete with stop and start in the same cycle; held delete is inert.
    del = 1; stop = 1; start = 1; step();
    stop = 0; start = 0;
    chk("t5_time", 32'({md0, st0, su0}), 32'h0000);
    chk("t5_stat", 32'({run0, pau0, fin0, tick0}), 32'h0);
    repeat (10) step();
    chk("t5_held", 32'({md0, st0, su0, run0, pau0, fin0, tick0}), 32'h0);
    del = 0; step();

    // Asynchronous reset between edges mid-RUN.
    repeat (3) pulse(P_SEC);
    start = 1; step(); start = 0;
    repeat (2) step();
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    chk("t6_async_time0", 32'({md0, st0, su0}), 32'h0000);
    chk("t6_async_stat0", 32'({run0, pau0, fin0, tick0}), 32'h0);
    chk("t6_async_time1", 32'({md1, st1, su1}), 32'h000);
    chk("t6_async_stat1", 32'({run1, pau1, fin1, tick1}), 32'h0);
    step();
    reset = 1'b0;
    repeat (60) pulse(P_SEC);
    chk("t6_sec_wrap", 32'({md0, st0, su0}), 32'h0000);

    // Randomised control traffic against the model.
    repeat (900) begin
      if ($urandom_range(0, 2) == 0) inc_sec = ~inc_sec;
      if ($urandom_range(0, 4) == 0) inc_min = ~inc_min;
      if ($urandom_range(0, 9) == 0) start = ~start;
      if ($urandom_range(0, 14) == 0) stop = ~stop;
      if ($urandom_range(0, 29) == 0) del = ~del;
      if ($urandom_range(0, 7) == 0) forward = ~forward;
      if ($urandom_range(0, 299) == 0) begin
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        check_model();
        step();
        reset = 1'b0;
      end else begin
        step();
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
